dmem_responder: RTL and testbench

Data-memory responder for the EX/MEM pipeline register. It takes the load/store request driven by the EX/MEM outputs (read/write strobes, ALU-result address, forwarded store data) and performs the access against an internal word-addressed RAM after a configurable number of wait states. While the access is pending it drives `mem_stall`, which freezes the EX/MEM register so the request stays stable. It returns load data to the MEM/WB side with a one-cycle valid pulse.

---
 rtl/dmem_responder.sv | 130 +++++++++++++
 tb/tb_dmem_responder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - EX/MEM data-memory responder with wait states and load-data return
// Optional misaligned-access trap: define DMEM_MISALIGN_TRAP_EN.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   rdata_q;
    logic          rdata_valid_q;
    logic          err_q;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          req;
    logic          commit;
    logic          misalign;
    logic [AW-1:0] idx;

    assign req = req_read | req_write;
    assign idx = req_addr[AW+1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
    logic unused_addr_hi;
    assign misalign       = |req_addr[1:0];
    assign unused_addr_hi = ^req_addr[31:AW+2];
    assign err            = err_q;
`else
    logic unused_bits;
    assign misalign    = 1'b0;
    assign unused_bits = ^{req_addr[31:AW+2], req_addr[1:0], err_q};
    assign err         = 1'b0;
`endif

    // A dropped request in WAIT is a pipeline flush: abort silently.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        commit    = 1'b0;
        mem_stall = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        commit = 1'b1;
                    end else begin
                        mem_stall = 1'b1;
                        state_d   = S_WAIT;
                        cnt_d     = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd1) begin
                    commit  = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    mem_stall = 1'b1;
                    cnt_d     = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        if (!rst) begin
            mem_stall = 1'b0;
            commit    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= 4'd0;
            rdata_q       <= 32'd0;
            rdata_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rdata_valid_q <= 1'b0;
            err_q         <= 1'b0;
            if (commit) begin
                if (misalign) begin
                    rdata_q <= 32'd0;
                    err_q   <= 1'b1;
                end else if (!req_write) begin
                    rdata_q       <= mem[idx];
                    rdata_valid_q <= 1'b1;
                end
            end
        end
    end

    // RAM contents survive reset; commit is already gated by rst.
    always_ff @(posedge clk) begin
        if (commit && req_write && !misalign) begin
            mem[idx] <= req_wdata;
        end
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder (WAIT_CYCLES 2 and 0)
module tb_dmem_responder;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst;
    logic        rd_i    [2];
    logic        wr_i    [2];
    logic [31:0] addr_i  [2];
    logic [31:0] wdata_i [2];
    logic        stall_o [2];
    logic [31:0] rdata_o [2];
    logic        valid_o [2];
    logic        err_o   [2];

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] ref_mem   [2][DEPTH];
    logic [31:0] ref_rdata [2];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u_dut_w2 (
        .clk(clk), .rst(rst),
        .req_read(rd_i[0]), .req_write(wr_i[0]),
        .req_addr(addr_i[0]), .req_wdata(wdata_i[0]),
        .mem_stall(stall_o[0]), .rdata(rdata_o[0]),
        .rdata_valid(valid_o[0]), .err(err_o[0])
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rst(rst),
        .req_read(rd_i[1]), .req_write(wr_i[1]),
        .req_addr(addr_i[1]), .req_wdata(wdata_i[1]),
        .mem_stall(stall_o[1]), .rdata(rdata_o[1]),
        .rdata_valid(valid_o[1]), .err(err_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    function automatic int wcyc(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Called mid-cycle; returns mid-cycle of the result cycle with the request still driven.
    task automatic access(input int d, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] wd);
        int  wc;
        int  idx;
        bit  mis;
        bit  exp_valid;
        bit  exp_err;
        wc  = wcyc(d);
        idx = int'((a % 32'(DEPTH * 4)) / 32'd4);
`ifdef DMEM_MISALIGN_TRAP_EN
        mis = (a % 32'd4) != 32'd0;
`else
        mis = 1'b0;
`endif
        exp_valid = r && !w && !mis;
        exp_err   = mis;
        if (mis)
            ref_rdata[d] = 32'd0;
        else if (exp_valid)
            ref_rdata[d] = ref_mem[d][idx];

        rd_i[d] = r; wr_i[d] = w; addr_i[d] = a; wdata_i[d] = wd;
        #1;
        chk($sformatf("dut%0d stall k0 a=%h", d, a), 32'(stall_o[d]), 32'(wc > 0));
        for (int k = 1; k <= wc; k++) begin
            @(negedge clk);
            chk($sformatf("dut%0d stall k%0d a=%h", d, k, a), 32'(stall_o[d]), 32'(k < wc));
            chk($sformatf("dut%0d early valid k%0d", d, k), 32'(valid_o[d]), 32'd0);
        end
        @(negedge clk);
        chk($sformatf("dut%0d valid a=%h r%0b w%0b", d, a, r, w), 32'(valid_o[d]), 32'(exp_valid));
        chk($sformatf("dut%0d err a=%h", d, a), 32'(err_o[d]), 32'(exp_err));
        chk($sformatf("dut%0d rdata a=%h", d, a), rdata_o[d], ref_rdata[d]);
        if (w && !mis)
            ref_mem[d][idx] = wd;
    endtask

    task automatic idle(input int d);
        rd_i[d] = 1'b0; wr_i[d] = 1'b0;
        #1;
        chk($sformatf("dut%0d idle stall", d), 32'(stall_o[d]), 32'd0);
        @(negedge clk);
        chk($sformatf("dut%0d idle valid", d), 32'(valid_o[d]), 32'd0);
        chk($sformatf("dut%0d idle err", d), 32'(err_o[d]), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rd_i[d] = 1'b0; wr_i[d] = 1'b0; addr_i[d] = '0; wdata_i[d] = '0;
            ref_rdata[d] = 32'd0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d reset stall", d), 32'(stall_o[d]), 32'd0);
            chk($sformatf("dut%0d reset rdata", d), rdata_o[d], 32'd0);
            chk($sformatf("dut%0d reset valid", d), 32'(valid_o[d]), 32'd0);
            chk($sformatf("dut%0d reset err", d), 32'(err_o[d]), 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);

        // RAM is not reset, so give every word a known value first.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < DEPTH; i++)
                access(d, 1'b0, 1'b1, 32'(i * 4), $urandom);
            idle(d);
        end

        access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0);
        idle(0);
        access(0, 1'b1, 1'b1, 32'h8, 32'h55);
        access(0, 1'b1, 1'b0, 32'h8, 32'h0);
        idle(0);

        // Flush after one WAIT cycle: no write, stall drops immediately.
        rd_i[0] = 1'b0; wr_i[0] = 1'b1; addr_i[0] = 32'h10; wdata_i[0] = 32'h12345678;
        #1;
        chk("abort stall c0", 32'(stall_o[0]), 32'd1);
        @(negedge clk);
        chk("abort stall c1", 32'(stall_o[0]), 32'd1);
        wr_i[0] = 1'b0;
        #1;
        chk("abort stall drop", 32'(stall_o[0]), 32'd0);
        @(negedge clk);
        chk("abort stall after", 32'(stall_o[0]), 32'd0);
        chk("abort valid after", 32'(valid_o[0]), 32'd0);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0);
        access(0, 1'b1, 1'b0, 32'h13, 32'h0);
        idle(0);

        // Reset in the middle of a pending write.
        rd_i[0] = 1'b0; wr_i[0] = 1'b1; addr_i[0] = 32'h20; wdata_i[0] = 32'hAAAA;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst mid-wait stall", 32'(stall_o[0]), 32'd0);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d rst2 stall", d), 32'(stall_o[d]), 32'd0);
            chk($sformatf("dut%0d rst2 rdata", d), rdata_o[d], 32'd0);
            chk($sformatf("dut%0d rst2 valid", d), 32'(valid_o[d]), 32'd0);
            chk($sformatf("dut%0d rst2 err", d), 32'(err_o[d]), 32'd0);
            ref_rdata[d] = 32'd0;
        end
        wr_i[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        access(0, 1'b1, 1'b0, 32'h20, 32'h0);
        idle(0);

        access(1, 1'b0, 1'b1, 32'h4, 32'h1234);
        access(1, 1'b1, 1'b0, 32'h4, 32'h0);
        access(1, 1'b1, 1'b0, 32'h13, 32'h0);
        idle(1);

        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 60; n++) begin
                int op;
                op = int'($urandom_range(1, 3));
                access(d, op[0], op[1], $urandom, $urandom);
                if ($urandom_range(0, 2) == 0)
                    idle(d);
            end
            idle(d);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
